imm_ext_pipe: RTL and testbench
===============================

Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate generator for the ARMv8 datapath. Successor to the combinational sign-extend unit.
- Takes the full 32-bit instruction plus a format select and produces the extended, pre-shifted immediate.
- Supports I, D, B, CB, IW (MOVZ/MOVK with hw shift) and shift-amount formats.
- Sits between decode and the ALU operand mux, behind a valid/ready handshake with back-pressure and a saturating error counter.

Parameters:
- DATA_W, 64, output width; legal values 32 or 64.
- STAGES, 2, pipeline depth. 1 = single registered stage; 2 = extract stage + shift stage.
- TAG_W, 5, width of the sideband tag carried alongside each request (e.g. destination register).

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  request valid.
- o_ready  out  1  block can accept a request this cycle.
- i_instr  in  32  raw instruction word.
- i_fmt  in  3  format: 0 I, 1 D, 2 B, 3 CB, 4 IW, 5 SHAMT, 6-7 reserved.
- i_tag  in  TAG_W  sideband, passed through unchanged.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_ext  out  DATA_W  extended immediate (signed).
- o_fmt  out  3  format of the current result.
- o_tag  out  TAG_W  tag of the current result.
- o_err  out  1  current result came from an illegal format/width combination.
- o_err_cnt  out  8  saturating count of erroneous results delivered.

Behaviour:
- Reset (i_rst=1 at clock edge):
  - Clears every stage valid bit, o_valid, o_err and o_err_cnt.
  - o_ext, o_fmt and o_tag reset to 0.
  - In-flight requests are discarded.
  - o_ready is 1 in the first cycle after reset.
- Extraction (bit indices refer to i_instr; result truncated to DATA_W):
  - I: zero-extend [21:10].
  - D: sign-extend [20:12]. Signed, unlike the old unit.
  - B: sign-extend [25:0], then shift left 2.
  - CB: sign-extend [23:5], then shift left 2.
  - IW: zero-extend [20:5], then shift left by 16*[22:21].
  - SHAMT: zero-extend [15:10].
- Errors:
  - Formats 6/7 give o_ext=0, o_err=1.
  - With DATA_W=32, IW with [22]=1 gives o_ext=0, o_err=1.
- STAGES=2 split:
  - Stage 1 registers the extended field, shift amount, fmt, tag and err.
  - Stage 2 applies the shift and registers the outputs.
- STAGES=1: extraction and shift are combinational into a single output register.
- Handshake:
  - A request is accepted when i_valid && o_ready.
  - A result is consumed when o_valid && i_ready.
  - Each stage loads when it is empty or its contents advance this cycle. o_ready is 1 when stage 1 is empty or stage 1 advances.
  - o_ready may depend combinationally on i_ready. No combinational path from i_valid to o_ready.
- Latency and throughput:
  - Accept to o_valid is STAGES cycles when not stalled.
  - Throughput is 1 result per cycle.
- Stall:
  - While o_valid && !i_ready, o_ext/o_fmt/o_tag/o_err hold stable.
  - With both stages full, o_ready=0.
  - No request is lost, duplicated or reordered.
- Simultaneous accept and consume on a full pipe: both happen; occupancy is unchanged.
- o_err_cnt increments on each consumed result with o_err=1, saturates at 255, and clears only on reset.
- Reset asserted together with i_valid: the request is not accepted.

Test Plan:
- ADD X0,X0,#0xFFF (0x913FFC00), fmt 0 → o_ext=0x0000000000000FFF, o_valid exactly 2 cycles after accept. With STAGES=1, 1 cycle.
- LDUR X0,[X0,#-8] (0xF85F8000), fmt 1 → o_ext=0xFFFFFFFFFFFFFFF8. B #-4 (0x17FFFFFF), fmt 2 → 0xFFFFFFFFFFFFFFFC. CBZ offset +3 words (0xB4000060), fmt 3 → 0x000000000000000C.
- MOVZ imm16=0xABCD, hw=3 (0xD2F579A0), fmt 4 → 0xABCD000000000000, o_err=0. Same word with DATA_W=32 → o_ext=0, o_err=1.
- Back-pressure: stream tags 1..6 back-to-back; drop i_ready for 3 cycles after the first output. Required: o_ready falls once both stages fill, outputs hold stable during the stall, and tags emerge 1..6 in order with no gaps or duplicates.
- Send 300 consumed requests with fmt 6 → every result o_ext=0, o_err=1; o_err_cnt reaches 255 and stays there.
- Assert i_rst for 1 cycle with 2 requests in flight → o_valid=0 and o_err_cnt=0 the next cycle, o_ready=1, no stale result appears later. A new request then completes with normal latency.

Source files
------------

// File: rtl/imm_ext_pipe.sv
// Pipelined ARMv8 immediate generator: extract/extend, then pre-shift, behind a
// valid/ready handshake with a saturating count of erroneous results.
module imm_ext_pipe #(
  parameter int DATA_W = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [31:0]       i_instr,
  input  logic [2:0]        i_fmt,
  input  logic [TAG_W-1:0]  i_tag,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_ext,
  output logic [2:0]        o_fmt,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_err,
  output logic [7:0]        o_err_cnt
);
  localparam logic [2:0] FMT_I  = 3'd0;
  localparam logic [2:0] FMT_D  = 3'd1;
  localparam logic [2:0] FMT_B  = 3'd2;
  localparam logic [2:0] FMT_CB = 3'd3;
  localparam logic [2:0] FMT_IW = 3'd4;
  localparam logic [2:0] FMT_SH = 3'd5;

  logic [63:0] fld_full;
  logic [5:0]  shamt;
  logic        err_c;

  always_comb begin
    fld_full = '0;
    shamt    = '0;
    err_c    = 1'b0;
    case (i_fmt)
      FMT_I:  fld_full = {52'd0, i_instr[21:10]};
      FMT_D:  fld_full = {{55{i_instr[20]}}, i_instr[20:12]};
      FMT_B: begin
        fld_full = {{38{i_instr[25]}}, i_instr[25:0]};
        shamt    = 6'd2;
      end
      FMT_CB: begin
        fld_full = {{45{i_instr[23]}}, i_instr[23:5]};
        shamt    = 6'd2;
      end
      FMT_IW: begin
        // hw of 2 or 3 would push the whole field out of a 32-bit result
        if (DATA_W == 32 && i_instr[22]) begin
          err_c = 1'b1;
        end else begin
          fld_full = {48'd0, i_instr[20:5]};
          shamt    = {i_instr[22:21], 4'd0};
        end
      end
      FMT_SH: fld_full = {58'd0, i_instr[15:10]};
      default: err_c = 1'b1;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{i_instr[31:26], i_instr[4:0], fld_full};

  logic              stg_valid;
  logic [DATA_W-1:0] stg_fld;
  logic [5:0]        stg_sh;
  logic [2:0]        stg_fmt;
  logic [TAG_W-1:0]  stg_tag;
  logic              stg_err;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_ext_q, out_ext_d;
  logic [2:0]        out_fmt_q, out_fmt_d;
  logic [TAG_W-1:0]  out_tag_q, out_tag_d;
  logic              out_err_q, out_err_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              out_free;

  assign out_free = !out_valid_q || i_ready;

  generate
    if (STAGES == 1) begin : g_one
      assign o_ready   = out_free;
      assign stg_valid = i_valid;
      assign stg_fld   = fld_full[DATA_W-1:0];
      assign stg_sh    = shamt;
      assign stg_fmt   = i_fmt;
      assign stg_tag   = i_tag;
      assign stg_err   = err_c;
    end else begin : g_two
      logic              s1_valid_q, s1_valid_d;
      logic [DATA_W-1:0] s1_fld_q, s1_fld_d;
      logic [5:0]        s1_sh_q, s1_sh_d;
      logic [2:0]        s1_fmt_q, s1_fmt_d;
      logic [TAG_W-1:0]  s1_tag_q, s1_tag_d;
      logic              s1_err_q, s1_err_d;

      assign o_ready = !s1_valid_q || out_free;

      always_comb begin
        s1_valid_d = s1_valid_q;
        s1_fld_d   = s1_fld_q;
        s1_sh_d    = s1_sh_q;
        s1_fmt_d   = s1_fmt_q;
        s1_tag_d   = s1_tag_q;
        s1_err_d   = s1_err_q;
        if (o_ready) begin
          s1_valid_d = i_valid;
          if (i_valid) begin
            s1_fld_d = fld_full[DATA_W-1:0];
            s1_sh_d  = shamt;
            s1_fmt_d = i_fmt;
            s1_tag_d = i_tag;
            s1_err_d = err_c;
          end
        end
      end

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          s1_valid_q <= 1'b0;
          s1_fld_q   <= '0;
          s1_sh_q    <= '0;
          s1_fmt_q   <= '0;
          s1_tag_q   <= '0;
          s1_err_q   <= 1'b0;
        end else begin
          s1_valid_q <= s1_valid_d;
          s1_fld_q   <= s1_fld_d;
          s1_sh_q    <= s1_sh_d;
          s1_fmt_q   <= s1_fmt_d;
          s1_tag_q   <= s1_tag_d;
          s1_err_q   <= s1_err_d;
        end
      end

      assign stg_valid = s1_valid_q;
      assign stg_fld   = s1_fld_q;
      assign stg_sh    = s1_sh_q;
      assign stg_fmt   = s1_fmt_q;
      assign stg_tag   = s1_tag_q;
      assign stg_err   = s1_err_q;
    end
  endgenerate

  always_comb begin
    out_valid_d = out_valid_q;
    out_ext_d   = out_ext_q;
    out_fmt_d   = out_fmt_q;
    out_tag_d   = out_tag_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;
    if (out_valid_q && i_ready && out_err_q && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
    if (out_free) begin
      out_valid_d = stg_valid;
      if (stg_valid) begin
        out_ext_d = stg_fld << stg_sh;
        out_fmt_d = stg_fmt;
        out_tag_d = stg_tag;
        out_err_d = stg_err;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_valid_q <= 1'b0;
      out_ext_q   <= '0;
      out_fmt_q   <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ext_q   <= out_ext_d;
      out_fmt_q   <= out_fmt_d;
      out_tag_q   <= out_tag_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_valid   = out_valid_q;
  assign o_ext     = out_ext_q;
  assign o_fmt     = out_fmt_q;
  assign o_tag     = out_tag_q;
  assign o_err     = out_err_q;
  assign o_err_cnt = err_cnt_q;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: default 64-bit/2-stage instance plus a 32-bit/1-stage
// instance that always accepts results, both checked against an arithmetic model.
module tb_imm_ext_pipe;
  localparam int ST = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, i_valid, i_ready, o_ready, o_valid, o_err;
  logic [31:0] i_instr;
  logic [2:0]  i_fmt, o_fmt;
  logic [4:0]  i_tag, o_tag;
  logic [63:0] o_ext;
  logic [7:0]  o_err_cnt;

  logic        ready32, o_ready32, o_valid32, o_err32;
  logic [31:0] o_ext32;
  logic [2:0]  o_fmt32;
  logic [4:0]  o_tag32;
  logic [7:0]  o_cnt32;

  imm_ext_pipe dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_fmt(i_fmt), .i_tag(i_tag), .o_valid(o_valid),
    .i_ready(i_ready), .o_ext(o_ext), .o_fmt(o_fmt), .o_tag(o_tag),
    .o_err(o_err), .o_err_cnt(o_err_cnt)
  );

  imm_ext_pipe #(.DATA_W(32), .STAGES(1), .TAG_W(5)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready32),
    .i_instr(i_instr), .i_fmt(i_fmt), .i_tag(i_tag), .o_valid(o_valid32),
    .i_ready(ready32), .o_ext(o_ext32), .o_fmt(o_fmt32), .o_tag(o_tag32),
    .o_err(o_err32), .o_err_cnt(o_cnt32)
  );

  typedef struct {
    logic [63:0] ext;
    logic [2:0]  fmt;
    logic [4:0]  tag;
    logic        err;
    int          acc;
  } item_t;

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  fmt;
    logic [63:0] e64;
    logic        err64;
    logic [31:0] e32;
    logic        err32;
  } vec_t;

  int    n_checks = 0;
  int    n_fail = 0;
  int    cyc = 0;
  item_t q[$];
  int    cnt_m = 0;
  item_t p32;
  logic  p32_v = 1'b0;
  int    cnt32 = 0;

  logic        s_valid, s_ready, s_err, s32_valid, s32_err;
  logic [63:0] s_ext;
  logic [4:0]  s_tag;
  logic [2:0]  s_fmt;
  logic [7:0]  s_cnt;
  logic [31:0] s32_ext;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference immediate: {err, value truncated to dw bits}
  function automatic logic [64:0] ref_ext(input logic [31:0] ins, input logic [2:0] f, input int dw);
    longint v;
    logic   err;
    v = 0;
    err = 1'b0;
    case (f)
      3'd0: v = longint'(ins[21:10]);
      3'd1: v = longint'($signed(ins[20:12]));
      3'd2: v = longint'($signed(ins[25:0])) * 4;
      3'd3: v = longint'($signed(ins[23:5])) * 4;
      3'd4: begin
        if (dw == 32 && ins[22]) err = 1'b1;
        else v = longint'(ins[20:5]) << (16 * ins[22:21]);
      end
      3'd5: v = longint'(ins[15:10]);
      default: err = 1'b1;
    endcase
    if (dw == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return {err, 64'(v)};
  endfunction

  task automatic cycle(input logic v, input logic [31:0] ins, input logic [2:0] f,
                       input logic [4:0] t, input logic r, output logic acc);
    logic        exp_v, exp_r, cons;
    logic [64:0] m;
    item_t       it;
    @(negedge clk);
    rst = 1'b0; i_valid = v; i_instr = ins; i_fmt = f; i_tag = t; i_ready = r;
    #1;
    exp_v = (q.size() > 0) && (cyc - q[0].acc >= ST - 1);
    exp_r = (q.size() < 2) || r;
    chk("o_valid", 64'(o_valid), 64'(exp_v));
    chk("o_ready", 64'(o_ready), 64'(exp_r));
    if (exp_v) begin
      chk("o_ext", o_ext, q[0].ext);
      chk("o_fmt", 64'(o_fmt), 64'(q[0].fmt));
      chk("o_tag", 64'(o_tag), 64'(q[0].tag));
      chk("o_err", 64'(o_err), 64'(q[0].err));
    end
    chk("o_err_cnt", 64'(o_err_cnt), 64'(cnt_m));
    chk("o_valid32", 64'(o_valid32), 64'(p32_v));
    chk("o_ready32", 64'(o_ready32), 64'd1);
    if (p32_v) begin
      chk("o_ext32", 64'(o_ext32), p32.ext);
      chk("o_err32", 64'(o_err32), 64'(p32.err));
      chk("o_tag32", 64'(o_tag32), 64'(p32.tag));
    end
    chk("o_err_cnt32", 64'(o_cnt32), 64'(cnt32));
    s_valid = o_valid; s_ready = o_ready; s_ext = o_ext; s_err = o_err;
    s_tag = o_tag; s_fmt = o_fmt; s_cnt = o_err_cnt;
    s32_valid = o_valid32; s32_ext = o_ext32; s32_err = o_err32;
    acc  = v && exp_r;
    cons = exp_v && r;
    @(posedge clk);
    cyc++;
    if (cons) begin
      if (q[0].err && cnt_m != 255) cnt_m++;
      void'(q.pop_front());
    end
    if (p32_v && p32.err && cnt32 != 255) cnt32++;
    if (acc) begin
      m = ref_ext(ins, f, 64);
      it.ext = m[63:0]; it.err = m[64]; it.fmt = f; it.tag = t; it.acc = cyc;
      q.push_back(it);
    end
    p32_v = v;
    if (v) begin
      m = ref_ext(ins, f, 32);
      p32.ext = m[63:0]; p32.err = m[64]; p32.fmt = f; p32.tag = t; p32.acc = cyc;
    end
  endtask

  task automatic do_reset(input logic v);
    @(negedge clk);
    rst = 1'b1; i_valid = v; i_instr = 32'h913F_FC00; i_fmt = 3'd0; i_tag = 5'd9; i_ready = 1'b1;
    @(posedge clk);
    cyc++;
    q.delete();
    cnt_m = 0; p32_v = 1'b0; cnt32 = 0;
  endtask

  task automatic measure(input logic [31:0] ins, input logic [2:0] f, input logic [4:0] t,
                         output int lat, output logic [63:0] ext, output logic err,
                         output logic v32, output logic [31:0] ext32, output logic err32);
    logic acc;
    bit   got;
    cycle(1'b1, ins, f, t, 1'b1, acc);
    lat = 0; got = 0; ext = '0; err = 1'b0; v32 = 1'b0; ext32 = '0; err32 = 1'b0;
    for (int k = 0; k < 6 && !got; k++) begin
      cycle(1'b0, 32'd0, 3'd0, 5'd0, 1'b1, acc);
      lat++;
      if (k == 0) begin v32 = s32_valid; ext32 = s32_ext; err32 = s32_err; end
      if (s_valid) begin got = 1; ext = s_ext; err = s_err; end
    end
    if (!got) lat = -1;
  endtask

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc, err, v32, err32, saw_block, seen_first;
    logic [63:0] ext;
    logic [31:0] ext32;
    logic [4:0]  tg;
    logic [4:0]  got_tags[$];
    int          lat, next_tag, stall, consumed;

    vecs[0]  = '{32'h913F_FC00, 3'd0, 64'h0000_0000_0000_0FFF, 1'b0, 32'h0000_0FFF, 1'b0};
    vecs[1]  = '{32'hF85F_8000, 3'd1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 32'hFFFF_FFF8, 1'b0};
    vecs[2]  = '{32'h17FF_FFFF, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0};
    vecs[3]  = '{32'hB400_0060, 3'd3, 64'h0000_0000_0000_000C, 1'b0, 32'h0000_000C, 1'b0};
    vecs[4]  = '{32'hD2F5_79A0, 3'd4, 64'hABCD_0000_0000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[5]  = '{32'h0000_FC00, 3'd5, 64'h0000_0000_0000_003F, 1'b0, 32'h0000_003F, 1'b0};
    vecs[6]  = '{32'hFFFF_FFFF, 3'd6, 64'h0,                   1'b1, 32'h0,         1'b1};
    vecs[7]  = '{32'hFFFF_FFFF, 3'd7, 64'h0,                   1'b1, 32'h0,         1'b1};
    vecs[8]  = '{32'h0022_4680, 3'd4, 64'h0000_0000_1234_0000, 1'b0, 32'h1234_0000, 1'b0};
    vecs[9]  = '{32'h00FF_FFE0, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0};
    vecs[10] = '{32'h000F_F000, 3'd1, 64'h0000_0000_0000_00FF, 1'b0, 32'h0000_00FF, 1'b0};

    ready32 = 1'b1;
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_instr = '0; i_fmt = '0; i_tag = '0;
    do_reset(1'b0);
    do_reset(1'b1);

    // reset state
    cycle(1'b0, 32'd0, 3'd0, 5'd0, 1'b1, acc);
    chk("rst_o_valid", 64'(s_valid), 64'd0);
    chk("rst_o_ready", 64'(s_ready), 64'd1);
    chk("rst_o_ext", s_ext, 64'd0);
    chk("rst_o_fmt", 64'(s_fmt), 64'd0);
    chk("rst_o_tag", 64'(s_tag), 64'd0);
    chk("rst_o_err", 64'(s_err), 64'd0);
    chk("rst_o_err_cnt", 64'(s_cnt), 64'd0);

    foreach (vecs[i]) begin
      tg = 5'(i + 3);
      measure(vecs[i].ins, vecs[i].fmt, tg, lat, ext, err, v32, ext32, err32);
      chk("vec_latency", 64'(lat), 64'(ST));
      chk("vec_ext", ext, vecs[i].e64);
      chk("vec_err", 64'(err), 64'(vecs[i].err64));
      chk("vec32_valid", 64'(v32), 64'd1);
      chk("vec32_ext", 64'(ext32), 64'(vecs[i].e32));
      chk("vec32_err", 64'(err32), 64'(vecs[i].err32));
    end

    // back-pressure: tags 1..6, stall 3 cycles after first output
    next_tag = 1; stall = 0; seen_first = 0; saw_block = 0;
    for (int c = 0; c < 40 && got_tags.size() < 6; c++) begin
      logic r;
      r = (stall == 0);
      cycle(next_tag <= 6, $urandom, 3'd0, next_tag[4:0], r, acc);
      if (acc) next_tag++;
      if (!s_ready) saw_block = 1;
      if (s_valid && r) got_tags.push_back(s_tag);
      if (stall > 0) stall--;
      if (s_valid && !seen_first) begin seen_first = 1; stall = 3; end
    end
    chk("bp_ready_fell", 64'(saw_block), 64'd1);
    chk("bp_count", 64'(got_tags.size()), 64'd6);
    foreach (got_tags[i]) chk("bp_tag_order", 64'(got_tags[i]), 64'(i + 1));

    // saturating error counter
    do_reset(1'b0);
    consumed = 0;
    for (int c = 0; c < 400 && consumed < 300; c++) begin
      cycle(1'b1, $urandom, 3'd6, 5'(c), 1'b1, acc);
      if (s_valid) consumed++;
    end
    chk("err_consumed", 64'(consumed), 64'd300);
    cycle(1'b1, 32'd0, 3'd6, 5'd0, 1'b1, acc);
    chk("err_cnt_sat", 64'(s_cnt), 64'd255);

    // reset with two requests in flight (counter currently saturated)
    cycle(1'b1, 32'h913F_FC00, 3'd0, 5'd1, 1'b0, acc);
    cycle(1'b1, 32'hF85F_8000, 3'd1, 5'd2, 1'b0, acc);
    do_reset(1'b1);
    cycle(1'b0, 32'd0, 3'd0, 5'd0, 1'b1, acc);
    chk("rif_o_valid", 64'(s_valid), 64'd0);
    chk("rif_err_cnt", 64'(s_cnt), 64'd0);
    chk("rif_o_ready", 64'(s_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 32'd0, 3'd0, 5'd0, 1'b1, acc);
      chk("rif_no_stale", 64'(s_valid), 64'd0);
    end
    measure(32'hB400_0060, 3'd3, 5'd7, lat, ext, err, v32, ext32, err32);
    chk("rif_latency", 64'(lat), 64'(ST));
    chk("rif_ext", ext, 64'h0000_0000_0000_000C);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      cycle($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
            5'($urandom), $urandom_range(0, 3) != 0, acc);
    end
    for (int c = 0; c < 10 && q.size() > 0; c++)
      cycle(1'b0, 32'd0, 3'd0, 5'd0, 1'b1, acc);
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
